// File: rtl/lab07_pkg.sv
// Shared types, widths and the golden sort-and-arith helpers for the Lab07 initiator.
package lab07_pkg;

    localparam int unsigned NUM_W   = 4;
    localparam int unsigned NUM_CNT = 4;
    localparam int unsigned RES_W   = 7;
    localparam int unsigned LAT_W   = 8;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned CMD_W   = NUM_W * NUM_CNT;
    localparam int unsigned ARITH_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef logic signed [NUM_W-1:0] num_t;

    // Mode arithmetic on already-sorted numbers, 8-bit signed, low 7 bits kept.
    function automatic logic [RES_W-1:0] lab07_arith(num_t s0, num_t s1, num_t s2, num_t s3,
                                                     logic [MODE_W-1:0] m);
        logic signed [ARITH_W-1:0] a0, a1, a2, a3, r;
        a0 = ARITH_W'(s0);
        a1 = ARITH_W'(s1);
        a2 = ARITH_W'(s2);
        a3 = ARITH_W'(s3);
        case (m)
            2'd0:    r = a0 + a1;
            2'd1:    r = a1 - a0;
            2'd2:    r = a3 - a2;
            default: r = a0 - a3;
        endcase
        return r[RES_W-1:0];
    endfunction

    // Full golden computation on a packed command (behavioural sort).
    function automatic logic [RES_W-1:0] lab07_golden_fn(logic [CMD_W-1:0] nums,
                                                         logic [MODE_W-1:0] m);
        num_t s [NUM_CNT];
        num_t t;
        for (int i = 0; i < NUM_CNT; i++) begin
            s[i] = nums[i*NUM_W +: NUM_W];
        end
        for (int i = 0; i < NUM_CNT - 1; i++) begin
            for (int j = 0; j < NUM_CNT - 1 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t      = s[j];
                    s[j]   = s[j+1];
                    s[j+1] = t;
                end
            end
        end
        return lab07_arith(s[0], s[1], s[2], s[3], m);
    endfunction

endpackage

// File: rtl/lab07_initiator_if.sv
// Command, core-facing and response signals of the Lab07 initiator.
interface lab07_initiator_if;
    import lab07_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CMD_W-1:0]      cmd_nums;
    logic [MODE_W-1:0]     cmd_mode;
    logic                  in_valid;
    logic [NUM_W-1:0]      in_number;
    logic [MODE_W-1:0]     mode;
    logic                  out_valid;
    logic [RES_W-1:0]      out_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [RES_W-1:0]      rsp_result;
    logic [LAT_W-1:0]      rsp_latency;
    logic                  rsp_timeout;
    logic                  rsp_mismatch;

    modport master (
        input  cmd_valid, cmd_nums, cmd_mode, out_valid, out_result, rsp_ready,
        output cmd_ready, in_valid, in_number, mode,
        output rsp_valid, rsp_result, rsp_latency, rsp_timeout, rsp_mismatch
    );

    modport slave (
        output cmd_valid, cmd_nums, cmd_mode, out_valid, out_result, rsp_ready,
        input  cmd_ready, in_valid, in_number, mode,
        input  rsp_valid, rsp_result, rsp_latency, rsp_timeout, rsp_mismatch
    );

endinterface

// File: rtl/lab07_golden.sv
// Golden reference: 4-input sorting network followed by the mode arithmetic.
module lab07_golden
    import lab07_pkg::*;
(
    input  logic [CMD_W-1:0]  nums,
    input  logic [MODE_W-1:0] mode,
    output logic [RES_W-1:0]  result_c
);

    num_t n0, n1, n2, n3;
    num_t a0, a1, a2, a3;
    num_t b0, b1, b2, b3;
    num_t c1, c2;

    function automatic num_t smin(num_t x, num_t y);
        return (x < y) ? x : y;
    endfunction

    function automatic num_t smax(num_t x, num_t y);
        return (x < y) ? y : x;
    endfunction

    // Three compare-exchange layers: (0,1)(2,3), (0,2)(1,3), (1,2).
    always_comb begin
        n0 = nums[0*NUM_W +: NUM_W];
        n1 = nums[1*NUM_W +: NUM_W];
        n2 = nums[2*NUM_W +: NUM_W];
        n3 = nums[3*NUM_W +: NUM_W];
        a0 = smin(n0, n1);
        a1 = smax(n0, n1);
        a2 = smin(n2, n3);
        a3 = smax(n2, n3);
        b0 = smin(a0, a2);
        b2 = smax(a0, a2);
        b1 = smin(a1, a3);
        b3 = smax(a1, a3);
        c1 = smin(b1, b2);
        c2 = smax(b1, b2);
        result_c = lab07_arith(b0, c1, c2, b3, mode);
    end

endmodule

// File: rtl/lab07_initiator.sv
// Lab07 initiator: serializes one command onto the core, waits for the answer
// under a timeout and returns result/latency/status on a valid/ready port.
// Optional macro LAB07_INITIATOR_CHECK_EN adds a golden-model result check.
module lab07_initiator
    import lab07_pkg::*;
#(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               rst,
    lab07_initiator_if.master  bus
);

    localparam int unsigned IDX_W  = $clog2(NUM_CNT);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                in_valid_q, in_valid_d;
    logic [NUM_W-1:0]    in_number_q, in_number_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [CMD_W-1:0]    nums_q, nums_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
    logic [LAT_W-1:0]    rsp_latency_q, rsp_latency_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                rsp_mismatch_q, rsp_mismatch_d;
    logic [LAT_W-1:0]    lat_inc;
    logic [RES_W-1:0]    golden;

`ifdef LAB07_INITIATOR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;

    lab07_golden u_golden (
        .nums     (nums_q),
        .mode     (mode_q),
        .result_c (golden)
    );
`else
    localparam bit CHECK_EN = 1'b0;

    assign golden = '0;
`endif

    // Saturating latency increment.
    assign lat_inc = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cmd_ready_q    <= 1'b0;
            in_valid_q     <= 1'b0;
            in_number_q    <= '0;
            mode_q         <= '0;
            nums_q         <= '0;
            idx_q          <= '0;
            lat_q          <= '0;
            wcnt_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_latency_q  <= '0;
            rsp_timeout_q  <= 1'b0;
            rsp_mismatch_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            in_valid_q     <= in_valid_d;
            in_number_q    <= in_number_d;
            mode_q         <= mode_d;
            nums_q         <= nums_d;
            idx_q          <= idx_d;
            lat_q          <= lat_d;
            wcnt_q         <= wcnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_latency_q  <= rsp_latency_d;
            rsp_timeout_q  <= rsp_timeout_d;
            rsp_mismatch_q <= rsp_mismatch_d;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d        = state_q;
        cmd_ready_d    = cmd_ready_q;
        in_valid_d     = in_valid_q;
        in_number_d    = in_number_q;
        mode_d         = mode_q;
        nums_d         = nums_q;
        idx_d          = idx_q;
        lat_d          = lat_q;
        wcnt_d         = wcnt_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_latency_d  = rsp_latency_q;
        rsp_timeout_d  = rsp_timeout_q;
        rsp_mismatch_d = rsp_mismatch_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                mode_d      = '0;
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d     = SEND;
                    cmd_ready_d = 1'b0;
                    nums_d      = bus.cmd_nums;
                    mode_d      = bus.cmd_mode;
                    in_valid_d  = 1'b1;
                    in_number_d = bus.cmd_nums[NUM_W-1:0];
                    idx_d       = '0;
                    lat_d       = '0;
                end
            end

            SEND: begin
                lat_d = lat_inc;
                if (idx_q == IDX_W'(NUM_CNT - 1)) begin
                    state_d     = WAIT;
                    in_valid_d  = 1'b0;
                    in_number_d = '0;
                    wcnt_d      = '0;
                end else begin
                    idx_d       = idx_q + IDX_W'(1);
                    in_number_d = nums_q[32'(idx_d) * NUM_W +: NUM_W];
                end
            end

            WAIT: begin
                lat_d = lat_inc;
                if (bus.out_valid) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_result_d   = bus.out_result;
                    rsp_latency_d  = lat_q;
                    rsp_timeout_d  = 1'b0;
                    rsp_mismatch_d = CHECK_EN && (bus.out_result != golden);
                end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_result_d   = '0;
                    rsp_latency_d  = lat_q;
                    rsp_timeout_d  = 1'b1;
                    rsp_mismatch_d = CHECK_EN;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d        = IDLE;
                    cmd_ready_d    = 1'b1;
                    mode_d         = '0;
                    rsp_valid_d    = 1'b0;
                    rsp_result_d   = '0;
                    rsp_latency_d  = '0;
                    rsp_timeout_d  = 1'b0;
                    rsp_mismatch_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.in_valid     = in_valid_q;
    assign bus.in_number    = in_number_q;
    assign bus.mode         = mode_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_latency  = rsp_latency_q;
    assign bus.rsp_timeout  = rsp_timeout_q;
    assign bus.rsp_mismatch = rsp_mismatch_q;

endmodule

// File: tb/tb_lab07_initiator.sv
// Bench for lab07_initiator: table of commands driven through a behavioural
// Lab07 core model, responses checked against a scoreboard queue.
module tb_lab07_initiator;
    import lab07_pkg::*;

    localparam int TB_TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lab07_initiator_if bus ();

    lab07_initiator #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] nums;
        logic [1:0]  mode;
        int          lat;
        logic [6:0]  reply;
        bit          silent;
        bit          spur;
        int          rdy_delay;
        logic [6:0]  exp_res;
    } vec_t;

    typedef struct {
        logic [6:0] res;
        logic [7:0] lat;
        bit         tmo;
        bit         mism;
        int         rise_off;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   first_iv_cyc = 0;
    exp_t sb [$];
    vec_t tv [7];

    logic [15:0] core_nums = '0;
    int          core_lat = 0;
    logic [6:0]  core_reply = '0;
    bit          core_silent = 1'b0;
    bit          core_spur = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: integer insertion sort plus mode arithmetic.
    function automatic logic [6:0] tb_golden(input logic [15:0] nums, input logic [1:0] m);
        int v [4];
        int key;
        int j;
        int r;
        logic signed [3:0] t;
        for (int i = 0; i < 4; i++) begin
            t    = nums[i*4 +: 4];
            v[i] = int'(t);
        end
        for (int i = 1; i < 4; i++) begin
            key = v[i];
            j   = i - 1;
            while (j >= 0 && v[j] > key) begin
                v[j+1] = v[j];
                j--;
            end
            v[j+1] = key;
        end
        case (m)
            2'd0:    r = v[0] + v[1];
            2'd1:    r = v[1] - v[0];
            2'd2:    r = v[3] - v[2];
            default: r = v[0] - v[3];
        endcase
        return 7'(r);
    endfunction

    always @(posedge clk) cyc_cnt++;

    // Behavioural core: checks the number stream and answers after core_lat cycles.
    initial begin : core_model
        bit         run;
        int         c;
        logic [3:0] en;
        run = 1'b0;
        c   = 0;
        bus.out_valid  = 1'b0;
        bus.out_result = '0;
        forever begin
            @(negedge clk);
            bus.out_valid = 1'b0;
            if (rst) begin
                run = 1'b0;
            end else if (!run) begin
                if (bus.in_valid) begin
                    run          = 1'b1;
                    c            = 0;
                    first_iv_cyc = cyc_cnt;
                end
            end else begin
                c++;
            end
            if (run) begin
                if (c < NUM_CNT) begin
                    en = core_nums[c*4 +: 4];
                    chk("in_valid_send", 32'(bus.in_valid), 32'd1);
                    chk("in_number", 32'(bus.in_number), 32'(en));
                end else if (c == NUM_CNT) begin
                    chk("in_valid_drop", 32'(bus.in_valid), 32'd0);
                    chk("in_number_zero", 32'(bus.in_number), 32'd0);
                    if (core_silent) run = 1'b0;
                end
                if (core_spur && c == 1) begin
                    bus.out_valid  = 1'b1;
                    bus.out_result = 7'h55;
                end
                if (!core_silent && c == core_lat) begin
                    bus.out_valid  = 1'b1;
                    bus.out_result = core_reply;
                    run            = 1'b0;
                end
            end
        end
    end

    task automatic wait_cmd_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   n;
        int   rise;
        core_nums   = v.nums;
        core_lat    = v.lat;
        core_reply  = v.reply;
        core_silent = v.silent;
        core_spur   = v.spur;

        e.res      = v.exp_res;
        e.lat      = 8'(v.lat);
        e.tmo      = v.silent;
`ifdef LAB07_INITIATOR_CHECK_EN
        e.mism     = v.silent ? 1'b1 : (v.reply != tb_golden(v.nums, v.mode));
`else
        e.mism     = 1'b0;
`endif
        e.rise_off = v.silent ? (NUM_CNT + TB_TIMEOUT) : (v.lat + 1);
        sb.push_back(e);

        wait_cmd_ready();
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_nums  = v.nums;
        bus.cmd_mode  = v.mode;
        @(posedge clk);
        #1;
        if (v.rdy_delay > 0) begin
            bus.cmd_nums = ~v.nums;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        @(negedge clk);
        chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
        chk("mode_fwd", 32'(bus.mode), 32'(v.mode));

        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
        rise = cyc_cnt;
        chk("rsp_rise_cycle", 32'(rise - first_iv_cyc), 32'(e.rise_off));

        for (int k = 0; k < v.rdy_delay; k++) begin
            chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("hold_rsp_result", 32'(bus.rsp_result), 32'(sb[0].res));
            @(negedge clk);
        end

        got = sb.pop_front();
        chk("rsp_result", 32'(bus.rsp_result), 32'(got.res));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(got.tmo));
        chk("rsp_mismatch", 32'(bus.rsp_mismatch), 32'(got.mism));
        if (!got.tmo) chk("rsp_latency", 32'(bus.rsp_latency), 32'(got.lat));
        chk("mode_held", 32'(bus.mode), 32'(v.mode));

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_mode", 32'(bus.mode), 32'd0);
    endtask

    task automatic reset_in_send();
        bit seen;
        core_nums   = 16'h4321;
        core_lat    = 60;
        core_reply  = 7'h11;
        core_silent = 1'b0;
        core_spur   = 1'b0;
        wait_cmd_ready();
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_nums  = 16'h4321;
        bus.cmd_mode  = 2'd2;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_valid", 32'(bus.in_valid), 32'd0);
        chk("rst_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
        chk("rst_mode", 32'(bus.mode), 32'd0);
        @(negedge clk);
        chk("rst_cmd_ready_high", 32'(bus.cmd_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid | bus.in_valid;
        end
        chk("rst_no_response", 32'(seen), 32'd0);
    endtask

    initial begin : main
        tv[0] = '{16'h07E3, 2'd0, 106, 7'h7E, 1'b0, 1'b0, 0, 7'h7E};
        tv[1] = '{16'h07E3, 2'd1, 106, 7'h02, 1'b0, 1'b0, 0, 7'h02};
        tv[2] = '{16'h07E3, 2'd1, 106, 7'h03, 1'b0, 1'b0, 0, 7'h03};
        tv[3] = '{16'h8778, 2'd3, 40, 7'h71, 1'b0, 1'b0, 0, 7'h71};
        tv[4] = '{16'h1234, 2'd2, 0, 7'h00, 1'b1, 1'b0, 0, 7'h00};
        tv[5] = '{16'h5A3C, 2'd2, 20, tb_golden(16'h5A3C, 2'd2), 1'b0, 1'b0, 5,
                  tb_golden(16'h5A3C, 2'd2)};
        tv[6] = '{16'hC396, 2'd0, 30, tb_golden(16'hC396, 2'd0), 1'b0, 1'b1, 0,
                  tb_golden(16'hC396, 2'd0)};

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_nums  = '0;
        bus.cmd_mode  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("reset_in_valid", 32'(bus.in_valid), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_mode", 32'(bus.mode), 32'd0);
        chk("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_pre", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_vec(tv[i]);
        end

        reset_in_send();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
